// File: rtl/branch_predictor_pkg.sv
// Shared encodings and default sizes for the dynamic branch predictor.
// Counter states follow the classic 2-bit scheme: MSB is the prediction.
package branch_predictor_pkg;

   localparam logic [1:0] PRED_SNT = 2'b00;
   localparam logic [1:0] PRED_WNT = 2'b01;
   localparam logic [1:0] PRED_WT  = 2'b10;
   localparam logic [1:0] PRED_ST  = 2'b11;

   localparam int PRED_IDX_W = 6;
   localparam int PRED_GHR_W = 4;

endpackage

// File: rtl/branch_predictor_sat_cnt2.sv
// 2-bit saturating counter next-state logic.
// Taken counts up to strongly-taken, not-taken counts down to strongly-not-taken.
module sat_cnt2
   import branch_predictor_pkg::*;
(
   input  logic [1:0] cnt,
   input  logic       taken,
   output logic [1:0] cnt_n
);

   // saturating step toward the resolved direction
   always_comb begin
      cnt_n = cnt;
      if (taken) begin
         if (cnt != PRED_ST)
            cnt_n = cnt + 2'd1;
      end else begin
         if (cnt != PRED_SNT)
            cnt_n = cnt - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal / gshare conditional-branch predictor with speculative global
// history, mispredict repair and saturating performance counters.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int         INDEX_W  = PRED_IDX_W,
   parameter int         GHR_W    = PRED_GHR_W,
   parameter int         GSHARE   = 1,
   parameter logic [1:0] CNT_INIT = PRED_WNT,
   parameter int         PERF_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              lkp_valid,
   input  logic [31:0]       lkp_pc,
   output logic              pred_taken,
   output logic [GHR_W-1:0]  pred_ghr,
   input  logic              upd_valid,
   input  logic [31:0]       upd_pc,
   input  logic [GHR_W-1:0]  upd_ghr,
   input  logic              upd_taken,
   input  logic              upd_mispred,
   output logic [PERF_W-1:0] perf_branch,
   output logic [PERF_W-1:0] perf_mispred
);

   localparam int DEPTH = 1 << INDEX_W;
   localparam logic [PERF_W-1:0] PERF_MAX = '1;

   logic [1:0]         tbl [DEPTH];
   logic [GHR_W-1:0]   ghr;
   logic [INDEX_W-1:0] lhist;
   logic [INDEX_W-1:0] uhist;
   logic [INDEX_W-1:0] lidx;
   logic [INDEX_W-1:0] uidx;
   logic [1:0]         cnt_n;
   logic               ghr_load;
   logic               ghr_bit;
   logic [GHR_W-1:0]   ghr_base;
   logic [GHR_W-1:0]   ghr_next;
   logic               unused_bits;

   assign lhist = (GSHARE != 0) ? INDEX_W'(ghr) : '0;
   assign uhist = (GSHARE != 0) ? INDEX_W'(upd_ghr) : '0;
   assign lidx  = lkp_pc[INDEX_W+1:2] ^ lhist;
   assign uidx  = upd_pc[INDEX_W+1:2] ^ uhist;

   // same-cycle writes are not bypassed: lookup sees the stored value
   assign pred_taken = tbl[lidx][1];
   assign pred_ghr   = ghr;

   sat_cnt2 u_cnt (
      .cnt   (tbl[uidx]),
      .taken (upd_taken),
      .cnt_n (cnt_n)
   );

   // history source: a mispredict repair overrides the speculative shift
   always_comb begin
      ghr_load = 1'b0;
      ghr_bit  = 1'b0;
      ghr_base = ghr;
      if (upd_valid && upd_mispred) begin
         ghr_load = 1'b1;
         ghr_bit  = upd_taken;
         ghr_base = upd_ghr;
      end else if (lkp_valid && !stall) begin
         ghr_load = 1'b1;
         ghr_bit  = pred_taken;
      end
   end

   generate
      if (GHR_W == 1) begin : g_ghr1
         assign ghr_next = ghr_bit;
      end else begin : g_ghrn
         assign ghr_next = {ghr_base[GHR_W-2:0], ghr_bit};
      end
   endgenerate

   assign unused_bits = ^{lkp_pc[31:INDEX_W+2], lkp_pc[1:0],
                          upd_pc[31:INDEX_W+2], upd_pc[1:0],
                          ghr_base[GHR_W-1]};

   // counter table training from the execute stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            tbl[i] <= CNT_INIT;
      end else if (upd_valid) begin
         tbl[uidx] <= cnt_n;
      end
   end

   // global history register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ghr <= '0;
      else if (ghr_load)
         ghr <= ghr_next;
   end

   // saturating resolved-branch and mispredict counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_branch  <= '0;
         perf_mispred <= '0;
      end else if (upd_valid) begin
         if (perf_branch != PERF_MAX)
            perf_branch <= perf_branch + PERF_W'(1);
         if (upd_mispred && perf_mispred != PERF_MAX)
            perf_mispred <= perf_mispred + PERF_W'(1);
      end
   end

endmodule
